// File: rtl/tff_ctrl_pkg.sv
// Shared state encoding and direction constants for the T flip-flop counter controller.
package tff_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_counter_ctrl_if.sv
// Command/status bundle between a run requester and the T flip-flop counter controller.
interface tff_counter_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic             stop;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t_vec;

  modport master (
    output start, dir, limit, stop,
    input  busy, done, count, t_vec
  );

  modport slave (
    input  start, dir, limit, stop,
    output busy, done, count, t_vec
  );

endinterface

// File: rtl/t_ff_r.sv
// Single T flip-flop: Q toggles on a rising edge when T is high; synchronous active-high reset to 0.
module t_ff_r (
  input  logic clk,
  input  logic Reset,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (Reset) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequences a bank of T flip-flops as an up/down counter: preset in LOAD, one step per RUN cycle,
// one-cycle DONE pulse; stop aborts LOAD/RUN with the count frozen.
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              Reset,
  tff_counter_ctrl_if.slave bus
);

  logic [1:0]       state;
  logic [1:0]       nxt_state;
  logic             dir_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] step_vec;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] end_val;
  logic             carry;

  assign load_val = (dir_q == DIR_UP) ? '0 : limit_q;
  assign end_val  = (dir_q == DIR_UP) ? limit_q : '0;

  // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
  always_comb begin
    step_vec = '0;
    carry    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step_vec[i] = carry;
      carry       = carry & ((dir_q == DIR_DOWN) ? ~q[i] : q[i]);
    end
  end

  always_comb begin
    nxt_state = state;
    t_vec     = '0;
    case (state)
      IDLE: begin
        if (bus.start) nxt_state = LOAD;
      end
      LOAD: begin
        if (bus.stop) begin
          nxt_state = IDLE;
        end else begin
          t_vec     = q ^ load_val;
          nxt_state = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          nxt_state = IDLE;
        end else if (q == end_val) begin
          nxt_state = DONE;
        end else begin
          t_vec = step_vec;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
    // Keep the observable enables quiet while reset is held.
    if (Reset) t_vec = '0;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      dir_q   <= DIR_UP;
      limit_q <= '0;
    end else begin
      state <= nxt_state;
      if (state == IDLE && bus.start) begin
        dir_q   <= bus.dir;
        limit_q <= bus.limit;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    t_ff_r u_tff (
      .clk   (clk),
      .Reset (Reset),
      .T     (t_vec[i]),
      .Q     (q[i])
    );
  end

  assign bus.busy  = (state == LOAD) || (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.count = q;
  assign bus.t_vec = t_vec;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed-vector bench for tff_counter_ctrl with hand-computed expectations.
module tb_tff_counter_ctrl;

  logic clk;
  logic Reset;
  int   checks;
  int   errors;

  tff_counter_ctrl_if #(.WIDTH(4)) bus ();

  tff_counter_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] cnt, input logic bsy, input logic dn);
    check({tag, ".count"}, {28'd0, bus.count}, {28'd0, cnt});
    check({tag, ".busy"},  {31'd0, bus.busy},  {31'd0, bsy});
    check({tag, ".done"},  {31'd0, bus.done},  {31'd0, dn});
  endtask

  task automatic kick(input logic d, input logic [3:0] lim);
    bus.start = 1'b1;
    bus.dir   = d;
    bus.limit = lim;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    Reset     = 1'b1;
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    bus.limit = 4'd5;
    bus.stop  = 1'b0;

    // Reset with start held: no run may begin.
    step();
    step();
    Reset     = 1'b0;
    bus.start = 1'b0;
    #1;
    expect_state("rst", 4'd0, 1'b0, 1'b0);
    check("rst.t_vec", {28'd0, bus.t_vec}, 32'd0);
    step();
    expect_state("rst_idle", 4'd0, 1'b0, 1'b0);

    // Up to 5.
    kick(1'b0, 4'd5);
    #1;
    check("up5.load_t", {28'd0, bus.t_vec}, 32'd0);
    check("up5.load_busy", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i <= 5; i++) begin
      step();
      expect_state($sformatf("up5.c%0d", i), i[3:0], 1'b1, 1'b0);
    end
    step();
    expect_state("up5.done", 4'd5, 1'b0, 1'b1);
    step();
    expect_state("up5.after", 4'd5, 1'b0, 1'b0);

    // Down from 9 starting at count 5: preset toggles only bits 3 and 2.
    kick(1'b1, 4'd9);
    #1;
    check("dn9.load_t", {28'd0, bus.t_vec}, 32'hC);
    step();
    expect_state("dn9.c9", 4'd9, 1'b1, 1'b0);
    check("dn9.t_at9", {28'd0, bus.t_vec}, 32'h1);
    for (int i = 8; i >= 0; i--) begin
      step();
      check($sformatf("dn9.c%0d", i), {28'd0, bus.count}, i);
      if (i == 8) check("dn9.t_at8", {28'd0, bus.t_vec}, 32'hF);
    end
    step();
    expect_state("dn9.done", 4'd0, 1'b0, 1'b1);
    step();
    expect_state("dn9.after", 4'd0, 1'b0, 1'b0);

    // limit 0: LOAD, RUN with immediate match, DONE; no toggles.
    kick(1'b0, 4'd0);
    #1;
    check("z.load_t", {28'd0, bus.t_vec}, 32'd0);
    step();
    check("z.run_t", {28'd0, bus.t_vec}, 32'd0);
    expect_state("z.run", 4'd0, 1'b1, 1'b0);
    step();
    expect_state("z.done", 4'd0, 1'b0, 1'b1);
    check("z.done_t", {28'd0, bus.t_vec}, 32'd0);

    // Full-range up run stops at all-ones without wrapping.
    step();
    kick(1'b0, 4'd15);
    for (int i = 0; i <= 15; i++) begin
      step();
      check($sformatf("up15.c%0d", i), {28'd0, bus.count}, i);
    end
    check("up15.t_at15", {28'd0, bus.t_vec}, 32'd0);
    step();
    expect_state("up15.done", 4'd15, 1'b0, 1'b1);
    step();
    expect_state("up15.after", 4'd15, 1'b0, 1'b0);

    // Up to 12 from 15, stray start in RUN, stop at 6.
    kick(1'b0, 4'd12);
    #1;
    check("stop.load_t", {28'd0, bus.t_vec}, 32'hF);
    step();
    check("stop.c0", {28'd0, bus.count}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      bus.start = (i == 3);
      bus.limit = (i == 3) ? 4'd2 : 4'd12;
      step();
      check($sformatf("stop.c%0d", i), {28'd0, bus.count}, i);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    #1;
    check("stop.t_forced", {28'd0, bus.t_vec}, 32'd0);
    step();
    bus.stop = 1'b0;
    expect_state("stop.idle", 4'd6, 1'b0, 1'b0);
    step();
    expect_state("stop.hold", 4'd6, 1'b0, 1'b0);

    // Reset mid-run at count 3, then a normal run.
    kick(1'b0, 4'd10);
    for (int i = 0; i <= 3; i++) step();
    check("mrst.c3", {28'd0, bus.count}, 32'd3);
    check("mrst.t_at3", {28'd0, bus.t_vec}, 32'h7);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    expect_state("mrst.idle", 4'd0, 1'b0, 1'b0);
    check("mrst.t", {28'd0, bus.t_vec}, 32'd0);
    step();
    expect_state("mrst.idle2", 4'd0, 1'b0, 1'b0);
    kick(1'b0, 4'd2);
    for (int i = 0; i <= 2; i++) step();
    expect_state("post.c2", 4'd2, 1'b1, 1'b0);
    step();
    expect_state("post.done", 4'd2, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_counter_ctrl.md
Name: tff_counter_ctrl

Overview:
Sequencing controller for a bank of T flip-flops, operated as a programmable up/down counter.
- On a start request it presets the bank to a start value by toggling only the differing bits.
- It then drives per-bit T enables each cycle until the terminal value is reached, signals done, and returns to idle.
- It sits between a simple start/stop command interface and the T flip-flop bank, which it instantiates internally.

Parameters:
WIDTH, 4, number of T flip-flops in the bank (counter width, >= 2)

Ports:
clk  input  1  single system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  request a counting run; sampled only in IDLE
dir  input  1  run direction, captured with start: 0 = up (0 -> limit), 1 = down (limit -> 0)
limit  input  WIDTH  terminal/start value, captured with start
stop  input  1  abort an active run (LOAD or RUN)
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse in DONE state
count  output  WIDTH  current Q vector of the flip-flop bank
t_vec  output  WIDTH  T enables driven to the bank this cycle (debug/observability)

Behaviour:
- Reset (sync, highest priority):
  - state = IDLE; all bank flip-flops = 0; captured dir/limit = 0.
  - busy = 0, done = 0, t_vec = 0.
- FSM states IDLE, LOAD, RUN, DONE. busy and done are Moore outputs decoded from state.
- IDLE:
  - t_vec = 0; count holds.
  - start = 1 captures dir/limit and moves to LOAD.
  - start is ignored in every other state.
- LOAD (exactly 1 cycle):
  - load_val = 0 if dir = up, else limit.
  - t_vec = count XOR load_val, so after the edge count = load_val.
  - Next state is RUN.
- RUN:
  - end_val = limit if up, else 0.
  - If count == end_val: t_vec = 0, next state DONE.
  - Else, up: t_vec[0] = 1 and t_vec[i] = AND of count[i-1:0].
  - Else, down: t_vec[0] = 1 and t_vec[i] = AND of ~count[i-1:0].
  - Exactly one increment or decrement per cycle.
- DONE (1 cycle): done = 1, t_vec = 0, next state IDLE. count holds the terminal value.
- stop in LOAD or RUN:
  - t_vec forced to 0 that cycle; next state IDLE; count holds its current value; no done pulse.
  - stop has priority over the terminal compare.
  - stop in IDLE or DONE is ignored.
- Latency: start sampled at edge k gives done high between edges k+limit+2 and k+limit+3, in both directions.
- limit = 0: the run is LOAD, then RUN with immediate match, then DONE. Zero counting toggles; done at k+2.
- limit = 2^WIDTH-1, up: counts 0 to all-ones with no wrap; the terminal compare stops it before overflow.
- Start while count is nonzero from a previous run: LOAD toggles only the bits that differ from load_val.
- start and stop high together in IDLE: start wins, because stop is ignored in IDLE.
- Reset mid-run: next cycle is IDLE with count = 0; no done pulse.

Decomposition:
- Package tff_ctrl_pkg:
  - State enum: IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3.
  - Constants DIR_UP = 1'b0, DIR_DOWN = 1'b1.
- Sub-module t_ff_r: one T flip-flop with synchronous active-high reset.
  - Ports: clk, Reset, T, Q.
  - Q toggles when T = 1.
  - Instantiated WIDTH times via generate; the controller drives T from t_vec.

Test Plan:
- Reset held 2 cycles, then released -> count = 0, busy = 0, done = 0, t_vec = 0. start = 1 together with Reset -> no run begins.
- WIDTH = 4, dir = 0, limit = 5, start pulse at edge k:
  - busy high at k+1 through k+6.
  - count goes 0,1,2,3,4,5.
  - done high for exactly one cycle at k+7, then IDLE with count = 5.
- From count = 5: dir = 1, limit = 9:
  - The LOAD cycle shows t_vec = 4'b1100 and count becomes 9.
  - count then goes 8..0, done pulses, and count = 0 is held.
- dir = 0, limit = 15 -> count reaches 15 with no wrap to 0; done pulses; count holds 15. limit = 0 -> done at k+2 with t_vec = 0 throughout.
- Up run with limit = 12, stop asserted when count = 6:
  - t_vec = 0 that cycle; count holds 6; no done pulse; busy drops next cycle.
  - start pulses during RUN have no effect.
- Reset asserted mid-RUN at count = 3 -> next cycle is IDLE, count = 0, busy = 0, no done pulse. A following start works normally.
